// File: rtl/sram_bist_pkg.sv
// Shared types and March C- element table for the SRAM BIST controller.
// Bit i of each table vector describes march element Mi.
package sram_bist_pkg;

    typedef enum logic [2:0] {
        ELEM_M0 = 3'd0,
        ELEM_M1 = 3'd1,
        ELEM_M2 = 3'd2,
        ELEM_M3 = 3'd3,
        ELEM_M4 = 3'd4,
        ELEM_M5 = 3'd5
    } elem_e;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_CHECK_LAST,
        ST_DONE
    } state_e;

    // M3 and M4 walk N-1 down to 0; every other element walks upwards.
    localparam logic [5:0] ELEM_DESCENDING = 6'b011000;
    localparam logic [5:0] ELEM_HAS_READ   = 6'b111110;
    localparam logic [5:0] ELEM_HAS_WRITE  = 6'b011111;
    localparam logic [5:0] ELEM_READ_INV   = 6'b010100;
    localparam logic [5:0] ELEM_WRITE_INV  = 6'b001010;

    function automatic logic elem_descending(input elem_e e);
        return ELEM_DESCENDING[e];
    endfunction

    function automatic logic elem_has_read(input elem_e e);
        return ELEM_HAS_READ[e];
    endfunction

    function automatic logic elem_has_write(input elem_e e);
        return ELEM_HAS_WRITE[e];
    endfunction

    function automatic logic elem_read_inv(input elem_e e);
        return ELEM_READ_INV[e];
    endfunction

    function automatic logic elem_write_inv(input elem_e e);
        return ELEM_WRITE_INV[e];
    endfunction

    function automatic elem_e next_elem(input elem_e e);
        elem_e n;
        case (e)
            ELEM_M0: n = ELEM_M1;
            ELEM_M1: n = ELEM_M2;
            ELEM_M2: n = ELEM_M3;
            ELEM_M3: n = ELEM_M4;
            ELEM_M4: n = ELEM_M5;
            default: n = ELEM_M5;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/sram_bist_checker.sv
// Read-data checker: remembers what each issued read should return, compares
// the macro output one cycle later and latches the first mismatch.
module sram_bist_checker
    import sram_bist_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clear_i,
    input  logic                  rd_issue_i,
    input  logic [DATA_WIDTH-1:0] rd_exp_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    input  logic [2:0]            rd_elem_i,
    input  logic [DATA_WIDTH-1:0] sram_dout_i,
    output logic                  mismatch_o,
    output logic [ADDR_WIDTH-1:0] fail_addr_o,
    output logic [2:0]            fail_elem_o,
    output logic [DATA_WIDTH-1:0] fail_mask_o
);

    logic                  rd_pending_q, rd_pending_d;
    logic [DATA_WIDTH-1:0] exp_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    elem_e                 elem_q;
    logic [ADDR_WIDTH-1:0] fail_addr_q, fail_addr_d;
    logic [2:0]            fail_elem_q, fail_elem_d;
    logic [DATA_WIDTH-1:0] fail_mask_q, fail_mask_d;
    logic [DATA_WIDTH-1:0] diff;
    logic                  mismatch;

    // dout is only meaningful in the cycle after a read edge, so the compare is
    // gated by rd_pending; a detected mismatch also cancels any read in flight.
    always_comb begin
        diff         = sram_dout_i ^ exp_q;
        mismatch     = rd_pending_q && (diff != '0);
        rd_pending_d = rd_issue_i && !mismatch;
        fail_addr_d  = fail_addr_q;
        fail_elem_d  = fail_elem_q;
        fail_mask_d  = fail_mask_q;
        if (clear_i) begin
            fail_addr_d = '0;
            fail_elem_d = '0;
            fail_mask_d = '0;
        end else if (mismatch) begin
            fail_addr_d = addr_q;
            fail_elem_d = elem_q;
            fail_mask_d = diff;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_pending_q <= 1'b0;
            exp_q        <= '0;
            addr_q       <= '0;
            elem_q       <= ELEM_M0;
            fail_addr_q  <= '0;
            fail_elem_q  <= '0;
            fail_mask_q  <= '0;
        end else begin
            rd_pending_q <= rd_pending_d;
            if (rd_issue_i) begin
                exp_q  <= rd_exp_i;
                addr_q <= rd_addr_i;
                elem_q <= elem_e'(rd_elem_i);
            end
            fail_addr_q <= fail_addr_d;
            fail_elem_q <= fail_elem_d;
            fail_mask_q <= fail_mask_d;
        end
    end

    assign mismatch_o  = mismatch;
    assign fail_addr_o = fail_addr_q;
    assign fail_elem_o = fail_elem_q;
    assign fail_mask_o = fail_mask_q;

endmodule

// File: rtl/sram_march_bist.sv
// March C- BIST controller: sequences the six elements over a single-port SRAM
// one operation per cycle and reports pass/fail with first-failure details.
module sram_march_bist
    import sram_bist_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 5,
    parameter logic [DATA_WIDTH-1:0] BACKGROUND = {DATA_WIDTH{1'b0}}
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  pass_o,
    output logic [ADDR_WIDTH-1:0] fail_addr_o,
    output logic [2:0]            fail_elem_o,
    output logic [DATA_WIDTH-1:0] fail_mask_o,
    output logic                  sram_we_o,
    output logic [ADDR_WIDTH-1:0] sram_addr_o,
    output logic [DATA_WIDTH-1:0] sram_din_o,
    input  logic [DATA_WIDTH-1:0] sram_dout_i
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = '1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(1);

    state_e                state_q, state_d;
    elem_e                 elem_q, elem_d;
    op_e                   op_q, op_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  we_q, we_d;
    logic [DATA_WIDTH-1:0] din_q, din_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  pass_q, pass_d;

    logic                  cur_desc, last_addr, last_op, run_end;
    logic                  chk_clear, chk_rd_issue, chk_mismatch;
    logic [DATA_WIDTH-1:0] chk_rd_exp;

    function automatic logic [DATA_WIDTH-1:0] pattern(input logic inv);
        return inv ? ~BACKGROUND : BACKGROUND;
    endfunction

    // The registered port op (elem_q/op_q/addr_q) is the op the macro sees this cycle.
    always_comb begin
        cur_desc     = elem_descending(elem_q);
        last_addr    = cur_desc ? (addr_q == '0) : (addr_q == ADDR_LAST);
        last_op      = (op_q == OP_WR) || !elem_has_write(elem_q);
        run_end      = last_addr && last_op && (elem_q == ELEM_M5);
        chk_rd_issue = (state_q == ST_RUN) && (op_q == OP_RD);
        chk_rd_exp   = pattern(elem_read_inv(elem_q));
    end

    always_comb begin
        state_d   = state_q;
        elem_d    = elem_q;
        op_d      = op_q;
        addr_d    = '0;
        we_d      = 1'b0;
        din_d     = '0;
        busy_d    = busy_q;
        done_d    = 1'b0;
        pass_d    = pass_q;
        chk_clear = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d   = ST_RUN;
                    elem_d    = ELEM_M0;
                    op_d      = OP_WR;
                    we_d      = 1'b1;
                    din_d     = pattern(elem_write_inv(ELEM_M0));
                    busy_d    = 1'b1;
                    pass_d    = 1'b0;
                    chk_clear = 1'b1;
                end
            end
            ST_RUN: begin
                if (chk_mismatch) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = 1'b0;
                end else if (run_end) begin
                    state_d = ST_CHECK_LAST;
                end else begin
                    addr_d = addr_q;
                    op_d   = OP_WR;
                    // Wrapping into the next element reloads the address from
                    // that element's direction, so the counter never leaves 0..N-1.
                    if (last_op) begin
                        if (last_addr) begin
                            elem_d = next_elem(elem_q);
                            addr_d = elem_descending(elem_d) ? ADDR_LAST : '0;
                        end else begin
                            addr_d = cur_desc ? (addr_q - ADDR_STEP) : (addr_q + ADDR_STEP);
                        end
                        op_d = elem_has_read(elem_d) ? OP_RD : OP_WR;
                    end
                    we_d  = (op_d == OP_WR);
                    din_d = we_d ? pattern(elem_write_inv(elem_d)) : '0;
                end
            end
            ST_CHECK_LAST: begin
                state_d = ST_DONE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                pass_d  = !chk_mismatch;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            elem_q  <= ELEM_M0;
            op_q    <= OP_RD;
            addr_q  <= '0;
            we_q    <= 1'b0;
            din_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            elem_q  <= elem_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            din_q   <= din_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    sram_bist_checker #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_checker (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clear_i     (chk_clear),
        .rd_issue_i  (chk_rd_issue),
        .rd_exp_i    (chk_rd_exp),
        .rd_addr_i   (addr_q),
        .rd_elem_i   (elem_q),
        .sram_dout_i (sram_dout_i),
        .mismatch_o  (chk_mismatch),
        .fail_addr_o (fail_addr_o),
        .fail_elem_o (fail_elem_o),
        .fail_mask_o (fail_mask_o)
    );

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign pass_o      = pass_q;
    assign sram_we_o   = we_q;
    assign sram_addr_o = addr_q;
    assign sram_din_o  = din_q;

endmodule

// File: tb/tb_sram_march_bist.sv
// Bench for sram_march_bist: behavioural SRAM with an injectable stuck-at cell
// and a March C- reference that predicts the port trace and first failure.
module tb_sram_march_bist;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int N  = 1 << AW;
    localparam logic [DW-1:0] BG = '0;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          busy, done, pass;
    logic [AW-1:0] failAddr;
    logic [2:0]    failElem;
    logic [DW-1:0] failMask;
    logic          sramWe;
    logic [AW-1:0] sramAddr;
    logic [DW-1:0] sramDin;
    logic [DW-1:0] sramDout;

    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;

    bit            faultOn;
    int            faultAddr;
    logic [DW-1:0] sa1Mask, sa0Mask;
    logic [DW-1:0] sramMem [N];

    typedef struct {
        bit            we;
        int            addr;
        logic [DW-1:0] din;
        int            elem;
        logic [DW-1:0] rdExp;
    } opT;
    opT opList[$];

    sram_march_bist #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .BACKGROUND (BG)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .busy_o      (busy),
        .done_o      (done),
        .pass_o      (pass),
        .fail_addr_o (failAddr),
        .fail_elem_o (failElem),
        .fail_mask_o (failMask),
        .sram_we_o   (sramWe),
        .sram_addr_o (sramAddr),
        .sram_din_o  (sramDin),
        .sram_dout_i (sramDout)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] cellRead(input int a, input logic [DW-1:0] stored);
        if (faultOn && a == faultAddr) return (stored & ~sa0Mask) | sa1Mask;
        return stored;
    endfunction

    always @(posedge clk) begin
        if (sramWe) begin
            sramMem[sramAddr] <= sramDin;
            sramDout          <= 'x;
        end else begin
            sramDout <= cellRead(int'(sramAddr), sramMem[sramAddr]);
        end
    end

    // Op codes: 0=w0 1=w1 2=r0 3=r1; -1 marks an unused slot.
    function automatic void buildMarch();
        int  dirDown [6]   = '{0, 0, 0, 1, 1, 0};
        int  opCode  [6][2] = '{'{0, -1}, '{2, 1}, '{3, 0}, '{2, 1}, '{3, 0}, '{2, -1}};
        opT  op;
        opList.delete();
        for (int e = 0; e < 6; e++) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < 2; j++) begin
                    if (opCode[e][j] >= 0) begin
                        op.addr  = dirDown[e] ? (N - 1 - i) : i;
                        op.elem  = e;
                        op.we    = (opCode[e][j] < 2);
                        op.din   = (opCode[e][j] == 1) ? ~BG : BG;
                        op.rdExp = (opCode[e][j] == 3) ? ~BG : BG;
                        opList.push_back(op);
                    end
                end
            end
        end
    endfunction

    function automatic void predict(output int failCyc, output int fAddr, output int fElem,
                                    output logic [DW-1:0] fMask);
        logic [DW-1:0] mem [N];
        logic [DW-1:0] got;
        failCyc = 0;
        fAddr   = 0;
        fElem   = 0;
        fMask   = '0;
        for (int i = 0; i < opList.size(); i++) begin
            if (opList[i].we) begin
                mem[opList[i].addr] = opList[i].din;
            end else begin
                got = cellRead(opList[i].addr, mem[opList[i].addr]);
                if (got !== opList[i].rdExp) begin
                    failCyc = i + 1;
                    fAddr   = opList[i].addr;
                    fElem   = opList[i].elem;
                    fMask   = got ^ opList[i].rdExp;
                    break;
                end
            end
        end
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic setFault(input bit on, input int a, input int bitIdx, input bit isSa1);
        faultOn   = on;
        faultAddr = a;
        sa1Mask   = (on && isSa1)  ? (DW'(1) << bitIdx) : '0;
        sa0Mask   = (on && !isSa1) ? (DW'(1) << bitIdx) : '0;
    endtask

    task automatic applyStimulus(input string tag, input bit holdStart);
        int            failCyc, expAddr, expElem, expDone, lastOpCycle;
        logic [DW-1:0] expMask;
        int            cyc, doneCycle, busyCycles, opErrors, firstBad, m3Errors, m3Idx;
        opT            op;
        predict(failCyc, expAddr, expElem, expMask);
        expDone     = (failCyc != 0) ? failCyc + 2 : 10 * N + 2;
        lastOpCycle = (failCyc != 0) ? failCyc + 1 : 10 * N;
        cyc = 0; doneCycle = 0; busyCycles = 0; opErrors = 0; firstBad = 0; m3Errors = 0;

        @(negedge clk);
        start = 1'b1;
        while (doneCycle == 0 && cyc < 10 * N + 20) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1 && !holdStart) start = 1'b0;
            if (cyc <= lastOpCycle) begin
                op = opList[cyc - 1];
                if (sramWe !== op.we || int'(sramAddr) != op.addr || (op.we && sramDin !== op.din)) begin
                    opErrors++;
                    if (firstBad == 0) firstBad = cyc;
                end
            end else if (sramWe !== 1'b0) begin
                opErrors++;
                if (firstBad == 0) firstBad = cyc;
            end
            if (cyc > 5 * N && cyc <= 7 * N) begin
                m3Idx = cyc - 5 * N - 1;
                if (int'(sramAddr) != N - 1 - m3Idx / 2 || sramWe !== 1'(m3Idx % 2) ||
                    (sramWe === 1'b1 && sramDin !== ~BG))
                    m3Errors++;
            end
            if (busy === 1'b1) busyCycles++;
            if (done === 1'b1) doneCycle = cyc;
        end

        checkOutput({tag, " done cycle"}, doneCycle, expDone);
        checkOutput({tag, " busy cycles"}, busyCycles, expDone - 1);
        checkOutput($sformatf("%s port trace (first bad cycle %0d)", tag, firstBad), opErrors, 0);
        checkOutput({tag, " pass"}, pass, (failCyc == 0));
        checkOutput({tag, " fail_addr"}, failAddr, expAddr);
        checkOutput({tag, " fail_elem"}, failElem, expElem);
        checkOutput({tag, " fail_mask"}, failMask, expMask);
        if (failCyc == 0) checkOutput({tag, " M3 address order"}, m3Errors, 0);

        @(negedge clk);
        checkOutput({tag, " done one cycle"}, done, 1'b0);
        checkOutput({tag, " idle after done"}, busy, 1'b0);
        if (holdStart) begin
            @(negedge clk);
            checkOutput({tag, " relaunch busy"}, busy, 1'b1);
            checkOutput({tag, " relaunch clears pass"}, pass, 1'b0);
            checkOutput({tag, " relaunch first write"}, {sramWe, sramAddr}, {1'b1, {AW{1'b0}}});
            start = 1'b0;
        end
    endtask

    initial begin
        buildMarch();
        setFault(1'b0, 0, 0, 1'b0);
        rst   = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset busy", busy, 1'b0);
        checkOutput("reset done", done, 1'b0);
        checkOutput("reset pass", pass, 1'b0);
        checkOutput("reset sram_we", sramWe, 1'b0);
        checkOutput("reset sram_addr", sramAddr, 0);
        checkOutput("reset sram_din", sramDin, 0);
        checkOutput("reset fail fields", {failAddr, failElem, failMask}, 0);
        rst = 1'b0;

        applyStimulus("fault-free", 1'b0);

        setFault(1'b1, 7, 3, 1'b1);
        applyStimulus("sa1 a7 b3", 1'b0);
        checkOutput("sa1 directed fail_elem", failElem, 1);
        checkOutput("sa1 directed fail_addr", failAddr, 7);
        checkOutput("sa1 directed fail_mask", failMask, 32'h8);

        setFault(1'b1, 31, 0, 1'b0);
        applyStimulus("sa0 a31 b0", 1'b0);
        checkOutput("sa0 directed fail_elem", failElem, 2);
        checkOutput("sa0 directed fail_addr", failAddr, 31);
        checkOutput("sa0 directed fail_mask", failMask, 32'h1);

        setFault(1'b0, 0, 0, 1'b0);
        applyStimulus("start held", 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (99) @(negedge clk);
        checkOutput("mid-run busy before reset", busy, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("mid-run reset busy", busy, 1'b0);
        checkOutput("mid-run reset sram_we", sramWe, 1'b0);
        checkOutput("mid-run reset sram_addr", sramAddr, 0);
        rst = 1'b0;
        applyStimulus("after reset", 1'b0);

        for (int r = 0; r < 6; r++) begin
            setFault(1'b1, $urandom_range(0, N - 1), $urandom_range(0, DW - 1), 1'($urandom_range(0, 1)));
            applyStimulus($sformatf("random fault %0d (addr %0d)", r, faultAddr), 1'b0);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/sram_march_bist.md
# sram_march_bist

March C- built-in self-test controller that drives the single-port synchronous SRAM macro interface from the initiator side. It issues the macro's `we`/`addr`/`din`, captures its `dout`, and checks every read against the expected background. It reports pass/fail and the first failing address, element and bit mask. It sits between the test/hammer control logic and one SRAM instance.

## Interface
- `DATA_WIDTH`, 32, word width; must match the macro.
- `ADDR_WIDTH`, 5, address width; depth `N = 1 << ADDR_WIDTH`.
- `BACKGROUND`, `{DATA_WIDTH{1'b0}}`, data written by "w0"; "w1" writes `~BACKGROUND`.
- `clk`  in  1  single clock; also clocks the SRAM.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  level-sampled; begins a run when sampled high in IDLE.
- `busy`  out  1  high from the start-accept edge until DONE.
- `done`  out  1  one-cycle pulse at end of run (pass or abort).
- `pass`  out  1  result of last completed run; 0 until one completes.
- `fail_addr`  out  ADDR_WIDTH  address of first mismatch.
- `fail_elem`  out  3  march element index (0–5) of first mismatch.
- `fail_mask`  out  DATA_WIDTH  `dout ^ expected` at first mismatch.
- `sram_we`  out  1  to macro `we`.
- `sram_addr`  out  ADDR_WIDTH  to macro `addr`.
- `sram_din`  out  DATA_WIDTH  to macro `din`.
- `sram_dout`  in  DATA_WIDTH  from macro `dout`; valid the cycle after a read (`we=0`) edge; X after a write edge.

## Operation
- **Elements:**
  - M0 ⇕(w0), ascending.
  - M1 ⇑(r0,w1).
  - M2 ⇑(r1,w0).
  - M3 ⇓(r0,w1).
  - M4 ⇓(r1,w0).
  - M5 ⇕(r0), ascending.
- **FSM:** IDLE → RUN → (CHECK_LAST) → DONE → IDLE.
  - RUN steps element, address and op (RD/WR).
  - Ascending: address 0→N-1. Descending: N-1→0.
  - Element advances when the last op at the last address issues.
- **Compare:**
  - A one-bit `rd_pending` flag plus the pipelined expected word, address and element mark the cycle whose `sram_dout` is checked.
  - Compare only when `rd_pending`; never sample `dout` after a write.
- **First mismatch:**
  - Latch `fail_addr`, `fail_elem` and `fail_mask`.
  - Abort: force `sram_we=0`, go to DONE, `pass=0`.
- **Clean finish:** after the final M5 read is checked, DONE with `pass=1`, `fail_*` = 0.
- **Start handling:**
  - `start` is ignored while `busy`.
  - Accepting a new `start` clears `pass` and `fail_*`.
  - `start` held high across DONE re-launches on the first IDLE cycle.
- **Reset:** returns to IDLE in one edge. Macro contents are undefined afterwards; no cleanup writes.
- **Addresses:** the address counter never wraps out of range. The descending element ends on `addr==0`.

## Timing
- **Reset values:**
  - `busy`, `done`, `pass`, `sram_we` = 0.
  - `sram_addr`, `sram_din` = 0.
  - `fail_*` = 0.
- All outputs are registered.
- **Run timeline:**
  - Start accepted at edge E0.
  - Port ops occupy cycles 1..10N, one op per cycle with no bubbles.
  - The final read is checked in cycle 10N+1.
  - `done` is high in cycle 10N+2 (322 for N=32); `busy` falls the same cycle.
- **Abort timing:** a read issued in cycle k that mismatches gives `done` in cycle k+2. No write issues after cycle k+1.
- **Port defaults:** in IDLE/DONE, `sram_we=0` and `sram_addr`, `sram_din` hold 0.

## Structure
- Package `sram_bist_pkg`:
  - element enum M0–M5
  - op enum RD/WR
  - FSM state enum
  - per-element direction and read/write polarity constants
- Sub-module `sram_bist_checker`:
  - pipelines expected word, address and element by one cycle
  - does the compare and first-fail latching
- Top holds the FSM and address counter.

## Test plan
- **Fault-free:** fault-free macro model, reset, pulse `start` → `busy` for 321 cycles, `done` pulse in cycle 322, `pass=1`, `fail_mask=0`.
- **Stuck-at-1:** bit 3 stuck-at-1 at addr 7 → `fail_elem=1`, `fail_addr=7`, `fail_mask=32'h8`, `pass=0`. `done` arrives 2 cycles after that read and no further writes issue.
- **Stuck-at-0:** bit 0 stuck-at-0 at addr 31 → `fail_elem=2`, `fail_addr=31`, `fail_mask=32'h1`.
- **Address ordering:** monitor M3 → addresses 31,31,30,30,…,0,0 with RD then WR at each, `din=~BACKGROUND` on WRs.
- **Start handling:** `start` held high through a run → no restart while `busy`. A new run begins the cycle after IDLE is re-entered and clears `pass`.
- **Reset mid-run:** assert `rst` in cycle 100 → next cycle `busy=0`, `sram_we=0`, `sram_addr=0`. A subsequent `start` completes with `pass=1`.
